// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures memory data into the IF/ID register, handles stall/flush/branch/halt.
// Latency: readAddress is the pc register (0 cycles), IF/ID updates 1 cycle later. A stall holds pc and IF/ID; a branch overrides a stall.
module fetch_stage #(
  parameter int                 ADDR_W     = 16,
  parameter int                 INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
  parameter int                 PC_STEP    = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  readAddress,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;

  assign readAddress = pc;
  assign pc_next_seq = pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            pc          <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            pc <= pc;
          end else if (flush) begin
            pc          <= pc_next_seq;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
          end else begin
            if_id_instr <= instruction;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
            // The halt word is consumed as a real instruction; pc parks on it.
            if (instruction == HALT_INSTR) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_next_seq;
            end
          end
        end
        HALT: begin
          if_id_instr <= NOP_INSTR;
          if_id_pc    <= pc;
          if_id_valid <= 1'b0;
          if (branch_taken) begin
            pc     <= branch_target;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
